// File: rtl/connect3x3_win_gen.sv
// Builds 3x3 windows from a raster pixel stream using two line buffers and
// serialises each complete window, one element per cycle, to the 3x3 counter.
module connect3x3_win_gen #(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8,
  parameter int CNT_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_vld,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_rdy,
  output logic              out_vld,
  output logic [DATA_W-1:0] out_data,
  output logic [3:0]        out_idx,
  output logic              out_last,
  output logic              frame_done
);

  localparam logic ACCEPT = 1'b0;
  localparam logic EMIT   = 1'b1;

  localparam int COL_AW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam logic [CNT_W-1:0] COL_LAST = CNT_W'(IMG_W - 1);
  localparam logic [CNT_W-1:0] ROW_LAST = CNT_W'(IMG_H - 1);
  localparam logic [CNT_W-1:0] TWO      = CNT_W'(2);
  localparam logic [3:0]       IDX_LAST = 4'd8;

  logic              state_q, state_d;
  logic [CNT_W-1:0]  row_q, row_d;
  logic [CNT_W-1:0]  col_q, col_d;
  logic [3:0]        idx_q, idx_d;
  logic              last_win_q, last_win_d;

  logic [DATA_W-1:0] lb0_q [IMG_W];
  logic [DATA_W-1:0] lb1_q [IMG_W];
  // Window stored row-major: element 3*r+c, row 0 oldest, column 0 leftmost.
  logic [DATA_W-1:0] win_q [9];

  logic              xfer;
  logic              win_ready;
  logic [COL_AW-1:0] col_a;

  assign xfer      = (state_q == ACCEPT) && in_vld;
  assign col_a     = col_q[COL_AW-1:0];
  assign win_ready = (row_q >= TWO) && (col_q >= TWO);

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    col_d      = col_q;
    idx_d      = idx_q;
    last_win_d = last_win_q;
    case (state_q)
      ACCEPT: begin
        if (xfer) begin
          if (col_q == COL_LAST) begin
            col_d = '0;
            row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
          end else begin
            col_d = col_q + 1'b1;
          end
          if (win_ready) begin
            state_d    = EMIT;
            idx_d      = '0;
            last_win_d = (row_q == ROW_LAST) && (col_q == COL_LAST);
          end
        end
      end
      default: begin
        if (idx_q == IDX_LAST) begin
          state_d = ACCEPT;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ACCEPT;
      row_q      <= '0;
      col_q      <= '0;
      idx_q      <= '0;
      last_win_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      col_q      <= col_d;
      idx_q      <= idx_d;
      last_win_q <= last_win_d;
    end
  end

  // Storage carries no reset: rows 0-1 never emit, so stale contents are never seen.
  always_ff @(posedge clk) begin
    if (xfer) begin
      lb1_q[col_a] <= lb0_q[col_a];
      lb0_q[col_a] <= in_data;
      win_q[0]     <= win_q[1];
      win_q[1]     <= win_q[2];
      win_q[2]     <= lb1_q[col_a];
      win_q[3]     <= win_q[4];
      win_q[4]     <= win_q[5];
      win_q[5]     <= lb0_q[col_a];
      win_q[6]     <= win_q[7];
      win_q[7]     <= win_q[8];
      win_q[8]     <= in_data;
    end
  end

  assign in_rdy     = (state_q == ACCEPT);
  assign out_vld    = (state_q == EMIT);
  assign out_data   = out_vld ? win_q[idx_q] : '0;
  assign out_idx    = idx_q;
  assign out_last   = out_vld && (idx_q == IDX_LAST);
  assign frame_done = out_last && last_win_q;

endmodule

// File: tb/tb_connect3x3_win_gen.sv
// Directed bench: a 4x4 instance for frame/stall/reset scenarios and an 8x8
// instance for the full default-size frame.
module tb_connect3x3_win_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst4, vld4, rdy4, ov4, ol4, fd4;
  logic [7:0] din4, od4;
  logic [3:0] oi4;
  logic       rst8, vld8, rdy8, ov8, ol8, fd8;
  logic [7:0] din8, od8;
  logic [3:0] oi8;

  connect3x3_win_gen #(.DATA_W(8), .IMG_W(4), .IMG_H(4), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst4), .in_vld(vld4), .in_data(din4), .in_rdy(rdy4),
    .out_vld(ov4), .out_data(od4), .out_idx(oi4), .out_last(ol4), .frame_done(fd4)
  );

  connect3x3_win_gen #(.DATA_W(8), .IMG_W(8), .IMG_H(8), .CNT_W(4)) dut8 (
    .clk(clk), .rst(rst8), .in_vld(vld8), .in_data(din8), .in_rdy(rdy8),
    .out_vld(ov8), .out_data(od8), .out_idx(oi8), .out_last(ol8), .frame_done(fd8)
  );

  int total = 0;
  int bad   = 0;
  int rdyLow4 = 0;
  int accCyc [64];

  // Captured element word: {frame_done, out_last, out_idx[3:0], out_data[7:0]}
  logic [13:0] gotQ4 [$];
  logic [13:0] gotQ8 [$];
  logic [13:0] expQ  [$];

  always @(negedge clk) begin
    if (ov4) gotQ4.push_back({fd4, ol4, oi4, od4});
    if (ov8) gotQ8.push_back({fd8, ol8, oi8, od8});
    if (!rdy4) rdyLow4++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic doReset(input bit big);
    @(negedge clk);
    if (big) begin rst8 = 1'b1; vld8 = 1'b0; end
    else     begin rst4 = 1'b1; vld4 = 1'b0; end
    repeat (2) @(negedge clk);
    if (big) rst8 = 1'b0; else rst4 = 1'b0;
  endtask

  // Reference model: window ending at (r,c) holds base + W*(r-2+i) + (c-2+j).
  task automatic buildExpected(input int w, input int h, input int base);
    for (int r = 2; r < h; r++)
      for (int c = 2; c < w; c++)
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++) begin
            logic lst, fdn;
            logic [3:0] ix;
            logic [7:0] d;
            lst = (i == 2) && (j == 2);
            fdn = lst && (r == h - 1) && (c == w - 1);
            ix  = 4'(3 * i + j);
            d   = 8'(base + w * (r - 2 + i) + (c - 2 + j));
            expQ.push_back({fdn, lst, ix, d});
          end
  endtask

  task automatic applyStimulus(input bit big, input int base, input int count, input bit gaps);
    int k = 0;
    int cyc = 0;
    bit v, r;
    while (k < count && cyc < 5000) begin
      @(negedge clk);
      v = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      r = big ? rdy8 : rdy4;
      if (big) begin vld8 = v; din8 = 8'(base + k); end
      else     begin vld4 = v; din4 = 8'(base + k); end
      @(posedge clk);
      if (v && r) begin
        accCyc[k] = cyc;
        k++;
      end
      cyc++;
    end
    if (k < count) checkOutput("drive_timeout", k, count);
  endtask

  task automatic drain(input bit big);
    int n = 0;
    @(negedge clk);
    if (big) vld8 = 1'b0; else vld4 = 1'b0;
    while (n < 40 && !((big ? rdy8 : rdy4) && !(big ? ov8 : ov4))) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) checkOutput("drain_timeout", n, 0);
  endtask

  task automatic compareQueues(input bit big, input string tag);
    int n;
    n = big ? gotQ8.size() : gotQ4.size();
    checkOutput({tag, "_count"}, n, expQ.size());
    for (int i = 0; i < n && i < expQ.size(); i++)
      checkOutput($sformatf("%s_elem%0d", tag, i), big ? gotQ8[i] : gotQ4[i], expQ[i]);
  endtask

  task automatic checkWindow(input string tag, input int start, input logic [7:0] vals [9]);
    for (int i = 0; i < 9; i++) begin
      if (start + i < gotQ4.size()) begin
        checkOutput($sformatf("%s_data%0d", tag, i), gotQ4[start + i][7:0], vals[i]);
        checkOutput($sformatf("%s_idx%0d", tag, i), gotQ4[start + i][11:8], i);
      end else begin
        checkOutput($sformatf("%s_missing%0d", tag, i), start + i, gotQ4.size());
      end
    end
  endtask

  function automatic int countBit(input bit big, input int pos);
    int n = 0;
    if (big) begin foreach (gotQ8[i]) n += int'(gotQ8[i][pos]); end
    else     begin foreach (gotQ4[i]) n += int'(gotQ4[i][pos]); end
    return n;
  endfunction

  logic [7:0] firstWin [9];
  logic [7:0] lastWin  [9];
  logic [7:0] secWin   [9];

  initial begin
    firstWin = '{8'd0, 8'd1, 8'd2, 8'd4, 8'd5, 8'd6, 8'd8, 8'd9, 8'd10};
    lastWin  = '{8'd5, 8'd6, 8'd7, 8'd9, 8'd10, 8'd11, 8'd13, 8'd14, 8'd15};
    secWin   = '{8'd100, 8'd101, 8'd102, 8'd104, 8'd105, 8'd106, 8'd108, 8'd109, 8'd110};
    rst4 = 1'b1; vld4 = 1'b0; din4 = '0;
    rst8 = 1'b1; vld8 = 1'b0; din8 = '0;

    // Reset state and scenario 1/2: continuous stream through a 4x4 frame
    doReset(1'b0);
    checkOutput("rst_out_vld", ov4, 0);
    checkOutput("rst_out_data", od4, 0);
    checkOutput("rst_out_idx", oi4, 0);
    checkOutput("rst_out_last", ol4, 0);
    checkOutput("rst_frame_done", fd4, 0);
    checkOutput("rst_in_rdy", rdy4, 1);
    gotQ4.delete(); expQ.delete(); rdyLow4 = 0;
    buildExpected(4, 4, 0);
    applyStimulus(1'b0, 0, 16, 1'b0);
    drain(1'b0);
    compareQueues(1'b0, "s1");
    checkWindow("s1_first", 0, firstWin);
    checkWindow("s1_last", 27, lastWin);
    checkOutput("s1_last_pulses", countBit(1'b0, 12), 4);
    checkOutput("s1_frame_done_pulses", countBit(1'b0, 13), 1);
    if (gotQ4.size() == 36) checkOutput("s1_fd_data", gotQ4[35], {1'b1, 1'b1, 4'd8, 8'd15});
    checkOutput("s2_pix10_after_9", accCyc[10] - accCyc[9], 1);
    checkOutput("s2_pix11_stall", accCyc[11] - accCyc[10], 10);
    checkOutput("s2_rdy_low_cycles", rdyLow4, 36);

    // Scenario 3: random input gaps give the same element sequence
    doReset(1'b0);
    gotQ4.delete(); expQ.delete();
    buildExpected(4, 4, 0);
    applyStimulus(1'b0, 0, 16, 1'b1);
    drain(1'b0);
    compareQueues(1'b0, "s3");

    // Scenario 4: two back-to-back frames
    doReset(1'b0);
    gotQ4.delete(); expQ.delete();
    buildExpected(4, 4, 0);
    buildExpected(4, 4, 100);
    applyStimulus(1'b0, 0, 16, 1'b0);
    applyStimulus(1'b0, 100, 16, 1'b0);
    drain(1'b0);
    compareQueues(1'b0, "s4");
    checkWindow("s4_second_first", 36, secWin);
    checkOutput("s4_frame_done_pulses", countBit(1'b0, 13), 2);

    // Scenario 5: reset at element 4 of the second window, then rerun the frame
    doReset(1'b0);
    gotQ4.delete();
    applyStimulus(1'b0, 0, 12, 1'b0);
    @(negedge clk);
    vld4 = 1'b0;
    checkOutput("s5_latency_vld", ov4, 1);
    checkOutput("s5_latency_idx", oi4, 0);
    repeat (4) @(negedge clk);
    checkOutput("s5_pre_rst_idx", oi4, 4);
    rst4 = 1'b1;
    @(negedge clk);
    rst4 = 1'b0;
    checkOutput("s5_post_rst_vld", ov4, 0);
    checkOutput("s5_post_rst_rdy", rdy4, 1);
    repeat (3) @(negedge clk);
    checkOutput("s5_aborted_count", gotQ4.size(), 14);
    gotQ4.delete(); expQ.delete();
    buildExpected(4, 4, 0);
    applyStimulus(1'b0, 0, 16, 1'b0);
    drain(1'b0);
    compareQueues(1'b0, "s5");

    // Scenario 6: default 8x8 frame with ramp data
    doReset(1'b1);
    gotQ8.delete(); expQ.delete();
    buildExpected(8, 8, 0);
    applyStimulus(1'b1, 0, 64, 1'b0);
    drain(1'b1);
    compareQueues(1'b1, "s6");
    checkOutput("s6_windows", countBit(1'b1, 12), 36);
    checkOutput("s6_frame_done_pulses", countBit(1'b1, 13), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/connect3x3_win_gen.md
Name: connect3x3_win_gen

Overview:
- Upstream feeder of the 3x3 window counter stage.
- Accepts a raster-ordered feature-map pixel stream, holds the two previous rows in line buffers, and builds a 3x3 window register array.
- For every fully-populated window, serialises its 9 elements one per cycle on out_vld/out_data. That serial stream is what the downstream 3x3 counter consumes.
- Stalls the input stream while a window is being emitted.

Parameters:
- DATA_W, 8, pixel width in bits.
- IMG_W, 8, feature-map columns (>=3).
- IMG_H, 8, feature-map rows (>=3).
- CNT_W, 4, width of the internal row/column counters (must hold max(IMG_W, IMG_H)-1).

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- in_vld  in  1  input pixel valid.
- in_data  in  DATA_W  input pixel, raster order (row-major, top-left first).
- in_rdy  out  1  block can accept a pixel this cycle.
- out_vld  out  1  one window element valid this cycle.
- out_data  out  DATA_W  window element.
- out_idx  out  4  element index 0..8 within the window, row-major.
- out_last  out  1  high with element 8.
- frame_done  out  1  high with element 8 of the final window of a frame.

Behaviour:
Reset:
- One clock is used. Reset is synchronous and active-high.
- Reset values: out_vld=0, out_data=0, out_idx=0, out_last=0, frame_done=0, in_rdy=1.
- Reset puts the FSM in ACCEPT and clears the row/col counters to 0.
- Line-buffer and window-register contents are not reset (don't-care).

FSM has two states, ACCEPT and EMIT.

ACCEPT:
- in_rdy=1 and out_vld=0.
- A transfer occurs when in_vld && in_rdy.
- On each transfer:
  - Window shifts one column left; the new right column is {lb1[col], lb0[col], in_data}, top to bottom.
  - lb1[col] <= lb0[col] and lb0[col] <= in_data.
  - col increments. At col==IMG_W-1 it wraps to 0 and row increments. At row==IMG_H-1 with col==IMG_W-1, both wrap to 0.
- If the accepted pixel had row>=2 && col>=2 (position before the increment), go to EMIT. Otherwise stay in ACCEPT.
- A cycle with no transfer changes nothing.

EMIT:
- in_rdy=0, so in_vld is ignored.
- Runs 9 consecutive cycles with out_vld=1 and out_idx=0..8.
- out_data = window[out_idx / 3][out_idx % 3], where row 0 is the oldest row and column 0 is the leftmost.
- out_last=1 only at idx 8.
- frame_done=1 at idx 8 only if the window came from pixel (IMG_H-1, IMG_W-1).
- After idx 8, return to ACCEPT. The next cycle has in_rdy=1.
- No output backpressure: the downstream stage accepts every cycle.
- Window contents are frozen during EMIT.

Timing:
- Latency: accept at cycle t puts idx 0 out at t+1 and idx 8 at t+9. in_rdy is low during t+1..t+9 and high again at t+10.
- Throughput: 1 pixel/cycle for non-window pixels; 10 cycles per window-producing pixel.
- Window count per frame: (IMG_H-2)*(IMG_W-2), giving 9x that many out_vld pulses.
- Row boundaries: columns 0 and 1 of each row never emit, so stale window columns from the previous row are never output.
- Frames run back-to-back with no gap. After frame_done the next accepted pixel is (0,0). Line-buffer contents from the previous frame are not read, because rows 0–1 never emit.

Reset mid-operation:
- rst during EMIT aborts the window. The next cycle has out_vld=0 and in_rdy=1, the counters are 0, and no further element of the aborted window appears.

Test Plan:
1. IMG_W=IMG_H=4, pixel(r,c)=4r+c, in_vld held high. Required:
   - 4 windows, 36 out_vld pulses.
   - First window data 0,1,2,4,5,6,8,9,10 with idx 0..8.
   - Last window 5,6,7,9,10,11,13,14,15.
   - out_last 4 times; frame_done once, with the final element 15.
2. Same frame, in_vld held high. Check:
   - in_rdy falls the cycle after pixel (2,2)=10 is accepted and stays low exactly 9 cycles.
   - Pixel 11 is not consumed until in_rdy returns.
   - Pixel order is unchanged (no drop or duplicate).
3. Same frame with random in_vld gaps (about 50% duty) → identical out_data/out_idx sequence to scenario 1. Only timing differs.
4. Two back-to-back 4x4 frames, second frame pixel=100+4r+c. Required:
   - Second frame's first window is 100,101,102,104,105,106,108,109,110.
   - frame_done pulses twice.
5. Assert rst at idx 4 of the second window. Required:
   - Next cycle out_vld=0 and in_rdy=1.
   - Restarting the frame from (0,0) reproduces scenario 1 exactly.
6. Default IMG_W=IMG_H=8 with ramp data → 36 windows, 324 out_vld pulses. Each window element (i,j) of the window ending at (r,c) equals 8(r-2+i)+(c-2+j).
